// File: rtl/convolution_pkg.sv
// rtl/convolution_pkg.sv - kernel constants and status encoding shared by the 3x3 Gaussian filter
package convolution_pkg;

  localparam int KERNEL_SHIFT = 4;

  // Rows top (r-2) to bottom (r), columns left (c-2) to right (c).
  localparam logic [2:0] KERNEL [3][3] = '{
    '{3'd1, 3'd2, 3'd1},
    '{3'd2, 3'd4, 3'd2},
    '{3'd1, 3'd2, 3'd1}
  };

  typedef enum logic [1:0] {
    FILLING = 2'd0,
    VALID   = 2'd1,
    WRAP    = 2'd2
  } valid_e;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - circular row delay: dout_o is the word written ROW_SIZE samples earlier
module line_buffer #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] din_i,
  output logic [WORD_SIZE-1:0] dout_o
);

  localparam int AW = $clog2(ROW_SIZE);
  localparam logic [AW-1:0] LAST = AW'(ROW_SIZE - 1);

  logic [WORD_SIZE-1:0] mem_q [ROW_SIZE];
  logic [AW-1:0]        ptr_q;
  logic [AW-1:0]        ptr_d;

  always_comb begin
    ptr_d = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Contents are left uncleared on reset; stale words are masked by the status output.
  always_ff @(posedge clk) begin
    mem_q[ptr_q] <= din_i;
  end

  assign dout_o = mem_q[ptr_q];

endmodule

// File: rtl/convolution.sv
// rtl/convolution.sv - streaming 3x3 Gaussian filter over a raster pixel stream
module convolution
  import convolution_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] inputPixel,
  output logic [WORD_SIZE-1:0] outputPixel,
  output logic [1:0]           valid
);

  localparam int CW    = $clog2(ROW_SIZE);
  localparam int ACC_W = WORD_SIZE + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);

  logic [CW-1:0]        col_q, col_d;
  logic [1:0]           row_q, row_d;
  valid_e               stat_q, stat_d;
  valid_e               valid_q;
  logic [WORD_SIZE-1:0] win_q [3][3];
  logic [WORD_SIZE-1:0] win_d [3][3];
  logic [WORD_SIZE-1:0] pix_q, pix_d;
  logic [WORD_SIZE-1:0] lb1_out, lb2_out;
  logic [ACC_W-1:0]     acc;

  line_buffer #(.WORD_SIZE(WORD_SIZE), .ROW_SIZE(ROW_SIZE)) u_lb1 (
    .clk    (clk),
    .rst    (rst),
    .din_i  (inputPixel),
    .dout_o (lb1_out)
  );

  line_buffer #(.WORD_SIZE(WORD_SIZE), .ROW_SIZE(ROW_SIZE)) u_lb2 (
    .clk    (clk),
    .rst    (rst),
    .din_i  (lb1_out),
    .dout_o (lb2_out)
  );

  always_comb begin
    col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
    row_d = row_q;
    if (col_q == COL_LAST && row_q != 2'd2) begin
      row_d = row_q + 2'd1;
    end

    // Status describes the sample being accepted this cycle; it is delayed once more to align with the sum.
    if (row_q != 2'd2) begin
      stat_d = FILLING;
    end else if (col_q < CW'(2)) begin
      stat_d = WRAP;
    end else begin
      stat_d = VALID;
    end

    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb2_out;
    win_d[1][2] = lb1_out;
    win_d[2][2] = inputPixel;

    acc = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        acc = acc + ACC_W'(win_q[i][j]) * ACC_W'(KERNEL[i][j]);
      end
    end
    pix_d = acc[KERNEL_SHIFT +: WORD_SIZE];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      stat_q  <= FILLING;
      valid_q <= FILLING;
      pix_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      stat_q  <= stat_d;
      valid_q <= stat_q;
      pix_q   <= pix_d;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= win_d[i][j];
        end
      end
    end
  end

  assign outputPixel = pix_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_convolution.sv
// tb/tb_convolution.sv - scoreboard bench for the streaming 3x3 Gaussian filter
module tb_convolution;

  localparam int W = 8;
  localparam int R = 8;
  localparam int K [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] inputPixel = '0;
  logic [W-1:0] outputPixel;
  logic [1:0]   valid;

  convolution #(.WORD_SIZE(W), .ROW_SIZE(R)) dut (
    .clk         (clk),
    .rst         (rst),
    .inputPixel  (inputPixel),
    .outputPixel (outputPixel),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [1:0] v;
    logic [7:0] p;
  } exp_t;

  exp_t sb[$];
  int   img[$];
  int   it;
  int   checks = 0;
  int   passed = 0;
  int   n_valid1, n_wrap, n_3f, n_1f, n_0f, first_valid;

  function automatic exp_t model(int n);
    exp_t e;
    int r, c, acc;
    r = n / R;
    c = n % R;
    acc = 0;
    e.idx = n;
    if (r < 2) e.v = 2'd0;
    else if (c < 2) e.v = 2'd2;
    else e.v = 2'd1;
    e.p = 8'h00;
    if (e.v == 2'd1) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          acc += K[i][j] * img[(r - 2 + i) * R + (c - 2 + j)];
      e.p = 8'(acc >> 4);
    end
    return e;
  endfunction

  function automatic int pix_gen(int mode, int n);
    case (mode)
      0: return 8'h80;
      1: return 8'hFF;
      2: return (n == 3 * R + 3) ? 8'hFF : 0;
      3: return n % 256;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic clear_model();
    sb.delete();
    img.delete();
    it = 0;
    n_valid1 = 0; n_wrap = 0; n_3f = 0; n_1f = 0; n_0f = 0;
    first_valid = -1;
  endtask

  // Outputs seen at the negedge before sample 'it' belong to the window ending at sample it-2.
  task automatic step(input bit push, input int pix);
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].idx == it - 2) begin
      e = sb.pop_front();
      checks++;
      if (valid !== e.v || (e.v == 2'd1 && outputPixel !== e.p))
        $display("FAIL sample %0d: valid=%0d pixel=%02h, required valid=%0d pixel=%02h",
                 e.idx, valid, outputPixel, e.v, e.p);
      else
        passed++;
      if (valid == 2'd2) n_wrap++;
      if (valid == 2'd1) begin
        n_valid1++;
        if (first_valid < 0) first_valid = e.idx;
        if (outputPixel == 8'h3F) n_3f++;
        if (outputPixel == 8'h1F) n_1f++;
        if (outputPixel == 8'h0F) n_0f++;
      end
    end
    inputPixel = 8'(pix);
    img.push_back(pix);
    if (push) sb.push_back(model(it));
    it++;
  endtask

  task automatic run_image(input int mode, input int npix);
    for (int n = 0; n < npix; n++) step(1'b1, pix_gen(mode, n));
    step(1'b0, 0);
    step(1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inputPixel = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (outputPixel !== 8'h00 || valid !== 2'd0)
      $display("FAIL reset_state: pixel=%02h valid=%0d, required 00/0", outputPixel, valid);
    else passed++;
    clear_model();
    @(posedge clk);
    #2 rst = 1'b0;
    run_image(4, R + 3);
  endtask

  task automatic test_constant(input int mode, input logic [7:0] level);
    do_reset();
    run_image(mode, 8 * R);
    checks++;
    if (n_valid1 !== 36)
      $display("FAIL const_%02h_count: got %0d valid outputs, required 36", level, n_valid1);
    else passed++;
  endtask

  task automatic test_impulse();
    do_reset();
    run_image(2, 8 * R);
    checks++;
    if (n_3f !== 1 || n_1f !== 4 || n_0f !== 4)
      $display("FAIL impulse_taps: 3F=%0d 1F=%0d 0F=%0d, required 1/4/4", n_3f, n_1f, n_0f);
    else passed++;
  endtask

  task automatic test_counting();
    do_reset();
    run_image(3, 8 * R);
    checks++;
    if (first_valid !== 2 * R + 2)
      $display("FAIL first_valid: window %0d, required %0d", first_valid, 2 * R + 2);
    else passed++;
    checks++;
    if (n_wrap !== 12)
      $display("FAIL wrap_count: got %0d, required 12", n_wrap);
    else passed++;
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int n = 0; n < 4 * R + 4; n++) step(1'b1, pix_gen(3, n));
    @(posedge clk);
    #2;
    checks++;
    if (valid !== 2'd1 || outputPixel === 8'h00)
      $display("FAIL pre_reset: valid=%0d pixel=%02h, required valid 1 with nonzero pixel", valid, outputPixel);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (outputPixel !== 8'h00 || valid !== 2'd0)
      $display("FAIL async_reset: pixel=%02h valid=%0d, required 00/0", outputPixel, valid);
    else passed++;
    clear_model();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    run_image(3, 3 * R);
    checks++;
    if (first_valid !== 2 * R + 2)
      $display("FAIL restart_first_valid: window %0d, required %0d", first_valid, 2 * R + 2);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_image(4, 14 * R);
    checks++;
    if (n_valid1 !== 12 * (R - 2))
      $display("FAIL long_stream_count: got %0d, required %0d", n_valid1, 12 * (R - 2));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_constant(0, 8'h80);
    test_constant(1, 8'hFF);
    test_impulse();
    test_counting();
    test_midstream_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
